// File: rtl/hex_word_streamer.sv
// Streams a WIDTH-bit word as ASCII hex characters, most significant nibble first.
// Optional CR/LF word terminator is built when HEX_CRLF_EN is defined.
module hex_word_streamer #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          UPPERCASE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned Digits = WIDTH / 4;
  localparam int unsigned IdxW   = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Digits - 1);

`ifdef HEX_CRLF_EN
  typedef enum logic [1:0] {StIdle, StDigit, StCr, StLf} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDigit} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] word_q;
  logic [IdxW-1:0]  idx_q;

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, n} - 8'h0a;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [WIDTH-1:0] w, input logic [IdxW-1:0] i);
    logic [WIDTH-1:0] sh;
    sh = w >> {i, 2'b00};
    return sh[3:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_q     <= '0;
      idx_q      <= '0;
      data_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_char   <= 8'h00;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (data_valid && data_ready) begin
            // First character comes straight from data_in so it is valid next cycle.
            word_q     <= data_in;
            idx_q      <= LastIdx;
            out_char   <= to_ascii(nibble_at(data_in, LastIdx));
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            data_ready <= 1'b0;
            state_q    <= StDigit;
          end else begin
            data_ready <= 1'b1;
          end
        end
        StDigit: begin
          if (out_ready) begin
            if (idx_q != '0) begin
              idx_q    <= idx_q - 1'b1;
              out_char <= to_ascii(nibble_at(word_q, idx_q - 1'b1));
            end else begin
`ifdef HEX_CRLF_EN
              out_char <= 8'h0d;
              state_q  <= StCr;
`else
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              data_ready <= 1'b1;
              state_q    <= StIdle;
`endif
            end
          end
        end
`ifdef HEX_CRLF_EN
        StCr: begin
          if (out_ready) begin
            out_char <= 8'h0a;
            state_q  <= StLf;
          end
        end
        StLf: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b1;
            state_q    <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_word_streamer.sv
// Scoreboard bench for hex_word_streamer: uppercase and lowercase instances, WIDTH=16.
module tb_hex_word_streamer;

  localparam int Digits = 4;
`ifdef HEX_CRLF_EN
  localparam int Nch = Digits + 2;
`else
  localparam int Nch = Digits;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  logic [15:0] lc_data_in = '0;
  logic        lc_data_valid = 1'b0;
  logic        lc_data_ready;
  logic [7:0]  lc_out_char;
  logic        lc_out_valid;
  logic        lc_out_ready = 1'b1;
  logic        lc_busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  byte exp_q[$];
  byte lc_q[$];
  string hexu = "0123456789ABCDEF";
  string hexl = "0123456789abcdef";

  hex_word_streamer #(.WIDTH(16), .UPPERCASE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  hex_word_streamer #(.WIDTH(16), .UPPERCASE(1'b0)) dut_lc (
    .clk(clk), .rst_n(rst_n), .data_in(lc_data_in), .data_valid(lc_data_valid),
    .data_ready(lc_data_ready), .out_char(lc_out_char), .out_valid(lc_out_valid),
    .out_ready(lc_out_ready), .busy(lc_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Characters are consumed at the next rising edge; compare them on the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL char_unexpected: got %h expected none", out_char);
      end else begin
        byte e;
        e = exp_q.pop_front();
        if (out_char !== e) begin
          n_fail++;
          $display("FAIL char: got %h expected %h", out_char, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && lc_out_valid && lc_out_ready) begin
      n_checks++;
      if (lc_q.size() == 0) begin
        n_fail++;
        $display("FAIL lc_char_unexpected: got %h expected none", lc_out_char);
      end else begin
        byte e;
        e = lc_q.pop_front();
        if (lc_out_char !== e) begin
          n_fail++;
          $display("FAIL lc_char: got %h expected %h", lc_out_char, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_word(input bit lc, input logic [15:0] w);
    logic [15:0] sh;
    for (int i = Digits - 1; i >= 0; i--) begin
      sh = w >> (4 * i);
      if (lc) lc_q.push_back(hexl[sh[3:0]]);
      else    exp_q.push_back(hexu[sh[3:0]]);
    end
`ifdef HEX_CRLF_EN
    if (lc) begin lc_q.push_back(8'h0d); lc_q.push_back(8'h0a); end
    else    begin exp_q.push_back(8'h0d); exp_q.push_back(8'h0a); end
`endif
  endfunction

  // Presents a word once data_ready is seen and returns just after the accept edge.
  task automatic send_word(input logic [15:0] w);
    int t;
    t = 0;
    while (!data_ready && t < 50) begin step(); t++; end
    n_checks++;
    if (!data_ready) begin
      n_fail++;
      $display("FAIL send_timeout: got data_ready=%b expected 1", data_ready);
    end
    data_in = w;
    data_valid = 1'b1;
    push_word(1'b0, w);
    step();
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({data_ready, out_valid, busy, out_char} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_vals: got rdy=%b vld=%b busy=%b char=%h expected 0 0 0 00",
               data_ready, out_valid, busy, out_char);
    end
    step();
    rst_n = 1'b1;
    n_checks++;
    if (data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_clk: got %b expected 0", data_ready);
    end
    step();
    n_checks++;
    if (data_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_reset: got rdy=%b vld=%b expected 1 0", data_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_word(16'ha5f0);
    for (int i = 0; i < Nch; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || data_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_stream[%0d]: got vld=%b busy=%b rdy=%b expected 1 1 0",
                 i, out_valid, busy, data_ready);
      end
      step();
    end
    n_checks++;
    if (busy !== 1'b0 || data_ready !== 1'b1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_end: got busy=%b rdy=%b vld=%b left=%0d expected 0 1 0 0",
               busy, data_ready, out_valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    bit ok;
    out_ready = 1'b1;
    send_word(16'h0f1e);
    t0 = cyc;
    send_word(16'hffff);
    n_checks++;
    if (cyc - t0 != Nch + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles expected %0d", cyc - t0, Nch + 1);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_idle: got busy expected idle"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    out_ready = 1'b1;
    send_word(16'h1234);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (out_char !== 8'h32 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got char=%h vld=%b expected 32 1", i, out_char, out_valid);
      end
    end
    out_ready = 1'b1;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_idle: got busy expected idle"); end
  endtask

  task automatic test_ignore();
    bit ok;
    out_ready = 1'b1;
    send_word(16'h0000);
    data_in = 16'hffff;
    data_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (data_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ignore_ready[%0d]: got %b expected 0", i, data_ready);
      end
      step();
    end
    data_valid = 1'b0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ignore_idle: got busy expected idle"); end
    step();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_latched: got busy=%b vld=%b expected 0 0", busy, out_valid);
    end
    send_word(16'hffff);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ones_idle: got busy expected idle"); end
  endtask

  task automatic test_lowercase();
    int t;
    t = 0;
    while (!lc_data_ready && t < 20) begin step(); t++; end
    lc_data_in = 16'hbeef;
    lc_data_valid = 1'b1;
    push_word(1'b1, 16'hbeef);
    step();
    lc_data_valid = 1'b0;
    t = 0;
    while ((lc_busy || lc_q.size() != 0) && t < 50) begin step(); t++; end
    n_checks++;
    if (lc_q.size() != 0 || lc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lc_done: got left=%0d busy=%b expected 0 0", lc_q.size(), lc_busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    send_word(16'hc0de);
    step();
    step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got vld=%b busy=%b rdy=%b expected 0 0 0", out_valid, busy, data_ready);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL post_abort[%0d]: got vld=%b busy=%b rdy=%b expected 0 0 1",
                 i, out_valid, busy, data_ready);
      end
    end
    send_word(16'h0009);
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL after_abort_idle: got busy expected idle"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_ignore();
    test_lowercase();
    test_reset_mid();
    step();
    n_checks++;
    if (exp_q.size() != 0 || lc_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d/%0d expected 0/0", exp_q.size(), lc_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
